ball_motion_ctrl: RTL and testbench

//  Per-frame ball physics stage that sits directly upstream of the VGA subsystem.

---
 rtl/ball_motion_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//   Per-frame ball physics stage feeding the VGA subsystem. On each frame
//   tick (synchronised falling edge of vert_sync) it turns accelerometer tilt
//   into a bounded X then Y step, probes the world map at the four icon
//   corners of each candidate position, and commits or rejects each axis.
//   Touching a goal tile in a committed pass latches gameover, after which
//   the position is frozen until sys_rst.
// Ports
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   vert_sync                 : async active-low vsync (frame tick source)
//   tilt_x, tilt_y            : signed tilt, +ve = right / down
//   map_rd_req/row/col        : registered map lookup, held until valid
//   map_rd_valid, map_rd_data : 1-cycle lookup response and pixel code
//   ball_loc_X, ball_loc_Y    : registered icon top-left position
//   gameover                  : sticky goal-reached flag
module ball_motion_ctrl #(
  parameter int unsigned START_X    = 16,
  parameter int unsigned START_Y    = 16,
  parameter int unsigned ICON_SIZE  = 16,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned DEAD_ZONE  = 8,
  parameter int unsigned TILT_SHIFT = 4,
  parameter int unsigned MAX_STEP   = 4,
  parameter logic [7:0]  WALL_CODE  = 8'h01,
  parameter logic [7:0]  GOAL_CODE  = 8'h02
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       vert_sync,
  input  logic [7:0] tilt_x,
  input  logic [7:0] tilt_y,
  output logic       map_rd_req,
  output logic [9:0] map_rd_row,
  output logic [9:0] map_rd_col,
  input  logic       map_rd_valid,
  input  logic [7:0] map_rd_data,
  output logic [9:0] ball_loc_X,
  output logic [9:0] ball_loc_Y,
  output logic       gameover
);

  localparam logic [9:0]        START_X_C  = 10'(START_X);
  localparam logic [9:0]        START_Y_C  = 10'(START_Y);
  localparam logic [9:0]        SPAN_C     = 10'(ICON_SIZE - 1);
  localparam logic signed [10:0] MAX_X_C   = 11'(SCREEN_W - ICON_SIZE);
  localparam logic signed [10:0] MAX_Y_C   = 11'(SCREEN_H - ICON_SIZE);
  localparam logic [8:0]        DEAD_C     = 9'(DEAD_ZONE);
  localparam logic [8:0]        MAX_STEP_C = 9'(MAX_STEP);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC_X   = 3'd1,
    PROBE_X  = 3'd2,
    COMMIT_X = 3'd3,
    CALC_Y   = 3'd4,
    PROBE_Y  = 3'd5,
    COMMIT_Y = 3'd6
  } state_t;

  // Signed step from a tilt sample; the 9-bit magnitude keeps -128 as 128.
  function automatic logic signed [10:0] tilt_step(input logic [7:0] tilt);
    logic [8:0] mag;
    logic [8:0] shifted;
    logic [8:0] lim;
    mag     = tilt[7] ? (9'd0 - {tilt[7], tilt}) : {1'b0, tilt};
    shifted = mag >> TILT_SHIFT;
    if (mag < DEAD_C) begin
      lim = 9'd0;
    end else if (shifted > MAX_STEP_C) begin
      lim = MAX_STEP_C;
    end else begin
      lim = shifted;
    end
    tilt_step = tilt[7] ? -$signed({2'b00, lim}) : $signed({2'b00, lim});
  endfunction

  // Position plus step, clamped to the on-screen range [0, max_pos].
  function automatic logic [9:0] clamp_pos(input logic [9:0] pos,
                                           input logic signed [10:0] step,
                                           input logic signed [10:0] max_pos);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + step;
    if (sum < 11'sd0) begin
      clamp_pos = 10'd0;
    end else if (sum > max_pos) begin
      clamp_pos = max_pos[9:0];
    end else begin
      clamp_pos = sum[9:0];
    end
  endfunction

  state_t     state_r, next_state_s;
  logic       vs_meta_r, vs_sync_r, vs_prev_r;
  logic       tick_s;
  logic [9:0] pos_x_r, pos_y_r, cand_r;
  logic [9:0] cand_x_s, cand_y_s;
  logic [1:0] corner_r, corner_nx_s;
  logic [9:0] base_col_s, base_row_s, issue_col_s, issue_row_s;
  logic       wall_r, goal_r, gameover_r;
  logic       req_r;
  logic [9:0] row_r, col_r;

  assign tick_s   = vs_prev_r & ~vs_sync_r;
  assign cand_x_s = clamp_pos(pos_x_r, tilt_step(tilt_x), MAX_X_C);
  assign cand_y_s = clamp_pos(pos_y_r, tilt_step(tilt_y), MAX_Y_C);

  // vsync synchroniser and edge history; idles high so reset makes no tick.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_meta_r <= 1'b1;
      vs_sync_r <= 1'b1;
      vs_prev_r <= 1'b1;
    end else begin
      vs_meta_r <= vert_sync;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an unmoved candidate skips straight to commit.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (tick_s && !gameover_r) begin
          next_state_s = CALC_X;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC_X: begin
        if (cand_x_s == pos_x_r) begin
          next_state_s = COMMIT_X;
        end else begin
          next_state_s = PROBE_X;
        end
      end
      PROBE_X: begin
        if (req_r && map_rd_valid && (corner_r == 2'd3)) begin
          next_state_s = COMMIT_X;
        end else begin
          next_state_s = PROBE_X;
        end
      end
      COMMIT_X: next_state_s = CALC_Y;
      CALC_Y: begin
        if (cand_y_s == pos_y_r) begin
          next_state_s = COMMIT_Y;
        end else begin
          next_state_s = PROBE_Y;
        end
      end
      PROBE_Y: begin
        if (req_r && map_rd_valid && (corner_r == 2'd3)) begin
          next_state_s = COMMIT_Y;
        end else begin
          next_state_s = PROBE_Y;
        end
      end
      COMMIT_Y: next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Address of the next corner to request: bit0 selects right edge, bit1 bottom.
  always_comb begin
    corner_nx_s = corner_r + 2'd1;
    base_col_s  = pos_x_r;
    base_row_s  = pos_y_r;
    case (state_r)
      CALC_X: begin
        corner_nx_s = 2'd0;
        base_col_s  = cand_x_s;
      end
      PROBE_X: base_col_s = cand_r;
      CALC_Y: begin
        corner_nx_s = 2'd0;
        base_row_s  = cand_y_s;
      end
      PROBE_Y: base_row_s = cand_r;
      default: corner_nx_s = corner_r + 2'd1;
    endcase
    issue_col_s = base_col_s + (corner_nx_s[0] ? SPAN_C : 10'd0);
    issue_row_s = base_row_s + (corner_nx_s[1] ? SPAN_C : 10'd0);
  end

  // Datapath: lookup handshake, wall/goal accumulation and axis commit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pos_x_r    <= START_X_C;
      pos_y_r    <= START_Y_C;
      cand_r     <= 10'd0;
      corner_r   <= 2'd0;
      wall_r     <= 1'b0;
      goal_r     <= 1'b0;
      gameover_r <= 1'b0;
      req_r      <= 1'b0;
      row_r      <= 10'd0;
      col_r      <= 10'd0;
    end else begin
      case (state_r)
        CALC_X, CALC_Y: begin
          cand_r <= (state_r == CALC_X) ? cand_x_s : cand_y_s;
          wall_r <= 1'b0;
          goal_r <= 1'b0;
          if ((next_state_s == PROBE_X) || (next_state_s == PROBE_Y)) begin
            req_r    <= 1'b1;
            corner_r <= corner_nx_s;
            row_r    <= issue_row_s;
            col_r    <= issue_col_s;
          end
        end
        PROBE_X, PROBE_Y: begin
          if (req_r) begin
            // Valid while idle never reaches here, so stray pulses are dropped.
            if (map_rd_valid) begin
              req_r <= 1'b0;
              if (map_rd_data == WALL_CODE) begin
                wall_r <= 1'b1;
              end
              if (map_rd_data == GOAL_CODE) begin
                goal_r <= 1'b1;
              end
            end
          end else begin
            req_r    <= 1'b1;
            corner_r <= corner_nx_s;
            row_r    <= issue_row_s;
            col_r    <= issue_col_s;
          end
        end
        COMMIT_X: begin
          // A wall anywhere in the pass vetoes both the move and the goal.
          if (!wall_r) begin
            pos_x_r <= cand_r;
            if (goal_r) begin
              gameover_r <= 1'b1;
            end
          end
        end
        COMMIT_Y: begin
          if (!wall_r) begin
            pos_y_r <= cand_r;
            if (goal_r) begin
              gameover_r <= 1'b1;
            end
          end
        end
        default: req_r <= 1'b0;
      endcase
    end
  end

  assign map_rd_req = req_r;
  assign map_rd_row = row_r;
  assign map_rd_col = col_r;
  assign ball_loc_X = pos_x_r;
  assign ball_loc_Y = pos_y_r;
  assign gameover   = gameover_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Testbench for ball_motion_ctrl: directed scenarios followed by randomized
// frames, checked against a frame-level reference model of the ball physics.
module tb_ball_motion_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       vert_sync = 1'b1;
  logic [7:0] tilt_x = 8'd0;
  logic [7:0] tilt_y = 8'd0;
  logic       map_rd_req;
  logic [9:0] map_rd_row;
  logic [9:0] map_rd_col;
  logic       map_rd_valid = 1'b0;
  logic [7:0] map_rd_data = 8'd0;
  logic [9:0] ball_loc_X;
  logic [9:0] ball_loc_Y;
  logic       gameover;

  ball_motion_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .vert_sync(vert_sync),
    .tilt_x(tilt_x), .tilt_y(tilt_y),
    .map_rd_req(map_rd_req), .map_rd_row(map_rd_row), .map_rd_col(map_rd_col),
    .map_rd_valid(map_rd_valid), .map_rd_data(map_rd_data),
    .ball_loc_X(ball_loc_X), .ball_loc_Y(ball_loc_Y), .gameover(gameover)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // world map selection and responder controls
  int map_mode = 0;
  int seed     = 0;
  int max_lat  = 3;
  bit hold     = 1'b0;
  bit inject   = 1'b0;

  // responder state
  bit         r_busy = 1'b0;
  bit         r_just = 1'b0;
  int         r_wait = 0;
  logic [9:0] r_row  = 10'd0;
  logic [9:0] r_col  = 10'd0;

  logic [19:0] req_log[$];
  logic [19:0] exp_q[$];

  // reference model state
  int mx  = 16;
  int my  = 16;
  bit mgo = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int map_code(input int row, input int col);
    case (map_mode)
      1:       return (col >= 36) ? 1 : 0;
      2:       return (row == 16 && col == 24) ? 2 : 0;
      3:       return (((row * 37 + col * 11 + seed) % 61) == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int step_of(input logic [7:0] t);
    int v;
    int mag;
    int s;
    v   = $signed(t);
    mag = (v < 0) ? -v : v;
    if (mag < 8) return 0;
    s = mag / 16;
    if (s > 4) s = 4;
    return (v < 0) ? -s : s;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame of the physics rules: X pass then Y pass using committed X.
  task automatic model_frame(input logic [7:0] tx, input logic [7:0] ty);
    int cand, c, r, code;
    bit w, g;
    exp_q.delete();
    if (mgo) return;
    cand = clamp(mx + step_of(tx), 624);
    if (cand != mx) begin
      w = 0; g = 0;
      for (int k = 0; k < 4; k++) begin
        c = cand + (k % 2) * 15;
        r = my + (k / 2) * 15;
        exp_q.push_back({10'(r), 10'(c)});
        code = map_code(r, c);
        if (code == 1) w = 1;
        if (code == 2) g = 1;
      end
      if (!w) begin
        mx = cand;
        if (g) mgo = 1;
      end
    end
    cand = clamp(my + step_of(ty), 464);
    if (cand != my) begin
      w = 0; g = 0;
      for (int k = 0; k < 4; k++) begin
        c = mx + (k % 2) * 15;
        r = cand + (k / 2) * 15;
        exp_q.push_back({10'(r), 10'(c)});
        code = map_code(r, c);
        if (code == 1) w = 1;
        if (code == 2) g = 1;
      end
      if (!w) begin
        my = cand;
        if (g) mgo = 1;
      end
    end
  endtask

  // Map responder: random latency, one valid per request, checks hold rules.
  initial begin
    forever begin
      @(negedge sys_clk);
      map_rd_valid = 1'b0;
      if (r_just) chk("req_drop_after_valid", map_rd_req, 0);
      r_just = 1'b0;
      if (inject) begin
        map_rd_valid = 1'b1;
        map_rd_data  = 8'h02;
        inject       = 1'b0;
      end else if (hold) begin
        r_busy = 1'b0;
      end else if (map_rd_req) begin
        if (!r_busy) begin
          r_busy = 1'b1;
          r_wait = $urandom_range(0, max_lat);
          r_row  = map_rd_row;
          r_col  = map_rd_col;
          req_log.push_back({map_rd_row, map_rd_col});
        end else begin
          chk("row_stable", map_rd_row, r_row);
          chk("col_stable", map_rd_col, r_col);
        end
        if (r_wait == 0) begin
          map_rd_valid = 1'b1;
          map_rd_data  = 8'(map_code(r_row, r_col));
          r_busy       = 1'b0;
          r_just       = 1'b1;
        end else begin
          r_wait--;
        end
      end else begin
        r_busy = 1'b0;
      end
    end
  end

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] ty, input string tag);
    int n;
    model_frame(tx, ty);
    req_log.delete();
    tilt_x = tx;
    tilt_y = ty;
    vert_sync = 1'b0;
    repeat (3) @(negedge sys_clk);
    vert_sync = 1'b1;
    n = 0;
    while (req_log.size() < exp_q.size() && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (12) @(negedge sys_clk);
    chk({tag, "_nreq"}, req_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
      chk({tag, "_probe"}, req_log[i], exp_q[i]);
    chk({tag, "_x"}, ball_loc_X, mx);
    chk({tag, "_y"}, ball_loc_Y, my);
    chk({tag, "_go"}, gameover, mgo);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    mx = 16; my = 16; mgo = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_x", ball_loc_X, 16);
    chk("rst_y", ball_loc_Y, 16);
    chk("rst_go", gameover, 0);
    chk("rst_req", map_rd_req, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // idle frames with zero tilt
    for (int i = 0; i < 3; i++) run_frame(8'd0, 8'd0, "idle");

    // basic move right
    run_frame(8'd64, 8'd0, "right");
    chk("right_x_const", ball_loc_X, 20);
    chk("right_col1", req_log.size() > 1 ? int'(req_log[1][9:0]) : -1, 35);

    // wall blocks X, Y still moves
    map_mode = 1;
    run_frame(8'd64, 8'd64, "wall");
    chk("wall_x_const", ball_loc_X, 20);
    chk("wall_y_const", ball_loc_Y, 20);

    // dead zone
    run_frame(8'd7, 8'd0, "dead");

    // walk left to X=2 then clamp at 0 with -128
    map_mode = 0;
    run_frame(8'hE0, 8'd0, "left2");
    for (int i = 0; i < 4; i++) run_frame(8'hC0, 8'd0, "left4");
    chk("left_at2", ball_loc_X, 2);
    run_frame(8'h80, 8'd0, "clamp0");
    chk("clamp0_const", ball_loc_X, 0);

    // reset while a request is outstanding, then a late valid
    hold = 1'b1;
    tilt_x = 8'd64;
    tilt_y = 8'd0;
    vert_sync = 1'b0;
    n = 0;
    while (!map_rd_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    vert_sync = 1'b1;
    chk("midrst_req_seen", map_rd_req, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_req", map_rd_req, 0);
    chk("midrst_x", ball_loc_X, 16);
    chk("midrst_y", ball_loc_Y, 16);
    sys_rst = 1'b0;
    mx = 16; my = 16; mgo = 1'b0;
    inject = 1'b1;
    repeat (4) @(negedge sys_clk);
    hold = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("late_req", map_rd_req, 0);
    chk("late_x", ball_loc_X, 16);
    chk("late_y", ball_loc_Y, 16);
    chk("late_go", gameover, 0);

    // goal tile
    run_frame(8'd64, 8'd0, "pregoal");
    map_mode = 2;
    run_frame(8'd64, 8'd0, "goal");
    chk("goal_const", gameover, 1);
    run_frame(8'd64, 8'd64, "frozen");
    run_frame(8'hC0, 8'hC0, "frozen");
    chk("frozen_x_const", ball_loc_X, 24);

    // randomized frames over a sparse random wall map
    do_reset();
    map_mode = 3;
    seed     = $urandom_range(0, 1000);
    max_lat  = 5;
    for (int i = 0; i < 1000; i++)
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
